// File: rtl/hub75_pkg.sv
// hub75_pkg: shared defaults, FSM state and pixel layout for the HUB75 pixel source
package hub75_pkg;
  localparam int DEF_COLS      = 64;
  localparam int DEF_SCAN_ROWS = 32;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_BASE_ON   = 32;
  typedef enum logic {CLEAR, RUN} state_e;
  typedef struct packed {
    logic [DEF_DEPTH-1:0] r;
    logic [DEF_DEPTH-1:0] g;
    logic [DEF_DEPTH-1:0] b;
  } pixel_t;
endpackage

// File: rtl/hub75_pixel_ram.sv
// hub75_pixel_ram: simple dual-port RAM, one write port, one registered read port
// Ports: i_clk; write i_we/i_waddr/i_wdata; read i_re/i_raddr -> o_rdata one cycle later (held otherwise).
// A read and write to the same address on one edge returns the old word.
module hub75_pixel_ram #(
  parameter int W  = 12,
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_raddr];
  end
  assign o_rdata = rdata_q;
endmodule

// File: rtl/hub75_pixel_source.sv
// hub75_pixel_source: frame buffer and bit-plane sequencer feeding a HUB75 scan controller
// Ports: i_clk/i_rst (async, active high); i_clear restarts buffer clear;
//   host write i_wr_valid/o_wr_ready/i_wr_x/i_wr_y/i_wr_rgb ({R,G,B});
//   scan read i_rd_en/i_rd_col/i_rd_row -> o_data_r/g/b ([0]=upper, [1]=lower half), o_rd_valid;
//   i_frame_done advances o_plane, o_on_time = BASE_ON<<o_plane;
//   i_swap/o_swap_pending for bank swapping.
// Build option: define DOUBLE_BUFFER_EN for front/back banks swapped on plane wrap;
//   otherwise a single bank, i_swap ignored and o_swap_pending tied low.
module hub75_pixel_source
  import hub75_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int SCAN_ROWS = DEF_SCAN_ROWS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BASE_ON   = DEF_BASE_ON,
  localparam int XW = $clog2(COLS),
  localparam int RW = $clog2(SCAN_ROWS),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [XW-1:0]      i_wr_x,
  input  logic [RW:0]        i_wr_y,
  input  logic [3*DEPTH-1:0] i_wr_rgb,
  input  logic               i_rd_en,
  input  logic [XW-1:0]      i_rd_col,
  input  logic [RW-1:0]      i_rd_row,
  output logic [1:0]         o_data_r,
  output logic [1:0]         o_data_g,
  output logic [1:0]         o_data_b,
  output logic               o_rd_valid,
  input  logic               i_frame_done,
  output logic [PW-1:0]      o_plane,
  output logic [15:0]        o_on_time,
  input  logic               i_swap,
  output logic               o_swap_pending
);
  localparam int AW = XW + RW;
  state_e          state_q, state_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic [PW-1:0]   plane_q, plane_d, plane_rd_q;
  logic            rd_valid_q, rd_zero_q;
  logic            clearing, wr_fire, wrap;
  logic [3*DEPTH-1:0] up, lo;
  logic [2:0][DEPTH-1:0] up_c, lo_c;
  assign clearing   = state_q == CLEAR;
  assign o_wr_ready = state_q == RUN;
  assign wr_fire    = i_wr_valid & o_wr_ready;
  assign wrap       = i_frame_done && plane_q == PW'(DEPTH - 1);
  always_comb begin
    state_d = i_clear ? CLEAR : (clearing && clr_q == '1) ? RUN : state_q;
    clr_d   = (i_clear || !clearing) ? '0 : clr_q + 1'b1;
    plane_d = !i_frame_done ? plane_q : wrap ? '0 : plane_q + 1'b1;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= CLEAR;
      clr_q      <= '0;
      plane_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
      plane_rd_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      plane_q    <= plane_d;
      rd_valid_q <= i_rd_en;
      if (i_rd_en) begin
        plane_rd_q <= plane_q;
        rd_zero_q  <= clearing;
      end
    end
  end
`ifdef DOUBLE_BUFFER_EN
  localparam int NB = 2;
  logic front_q, front_d, pend_q, pend_d, rd_bank_q;
  logic [NB-1:0] bank_we;
  // The swap is taken only on the frame_done that returns to plane 0,
  // so a displayed frame never mixes banks across its planes.
  always_comb begin
    front_d = front_q ^ (wrap & pend_q);
    pend_d  = (wrap & pend_q) ? i_swap : (pend_q | i_swap);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      front_q <= front_d;
      pend_q  <= pend_d;
      if (i_rd_en) rd_bank_q <= front_q;
    end
  end
  assign bank_we        = front_q ? 2'b01 : 2'b10;
  assign o_swap_pending = pend_q;
`else
  localparam int NB = 1;
  logic [NB-1:0] bank_we;
  logic unused_swap;
  assign bank_we        = 1'b1;
  assign o_swap_pending = 1'b0;
  assign unused_swap    = i_swap;
`endif
  // Instance i = 2*bank + half; half 0 is the upper panel half.
  logic [2*NB-1:0][3*DEPTH-1:0] dout;
  for (genvar i = 0; i < 2 * NB; i++) begin : g_ram
    hub75_pixel_ram #(.W(3 * DEPTH), .AW(AW)) u_ram (
      .i_clk  (i_clk),
      .i_we   (clearing | (wr_fire & (i_wr_y[RW] == 1'(i % 2)) & bank_we[i / 2])),
      .i_waddr(clearing ? clr_q : {i_wr_y[RW-1:0], i_wr_x}),
      .i_wdata(clearing ? '0 : i_wr_rgb),
      .i_re   (i_rd_en),
      .i_raddr({i_rd_row, i_rd_col}),
      .o_rdata(dout[i])
    );
  end
`ifdef DOUBLE_BUFFER_EN
  assign up = rd_bank_q ? dout[2] : dout[0];
  assign lo = rd_bank_q ? dout[3] : dout[1];
`else
  assign up = dout[0];
  assign lo = dout[1];
`endif
  assign up_c = up;
  assign lo_c = lo;
  // Reads issued while clearing return zero since the buffer is only partly wiped.
  assign o_data_r   = rd_zero_q ? 2'b00 : {lo_c[2][plane_rd_q], up_c[2][plane_rd_q]};
  assign o_data_g   = rd_zero_q ? 2'b00 : {lo_c[1][plane_rd_q], up_c[1][plane_rd_q]};
  assign o_data_b   = rd_zero_q ? 2'b00 : {lo_c[0][plane_rd_q], up_c[0][plane_rd_q]};
  assign o_rd_valid = rd_valid_q;
  assign o_plane    = plane_q;
  assign o_on_time  = 16'(BASE_ON << plane_q);
endmodule

// File: tb/tb_hub75_pixel_source.sv
// tb_hub75_pixel_source: scoreboard bench for hub75_pixel_source
module tb_hub75_pixel_source;
  import hub75_pkg::*;
  logic        clk = 1'b0;
  logic        rst, clr, wr_valid, wr_ready, rd_en, rd_valid, frame_done, swap, swap_pending;
  logic [5:0]  wr_x, wr_y, rd_col;
  logic [11:0] wr_rgb;
  logic [4:0]  rd_row;
  logic [1:0]  dr, dg, db, plane;
  logic [15:0] on_time;
  int          total = 0;
  int          bad = 0;
  logic [5:0]  exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  hub75_pixel_source dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clr),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_x(wr_x), .i_wr_y(wr_y), .i_wr_rgb(wr_rgb),
    .i_rd_en(rd_en), .i_rd_col(rd_col), .i_rd_row(rd_row),
    .o_data_r(dr), .o_data_g(dg), .o_data_b(db), .o_rd_valid(rd_valid),
    .i_frame_done(frame_done), .o_plane(plane), .o_on_time(on_time),
    .i_swap(swap), .o_swap_pending(swap_pending)
  );

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input pixel_t p);
    wr_valid = 1'b1; wr_x = 6'(x); wr_y = 6'(y); wr_rgb = p;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int row, input int col, input logic [5:0] e, input string n);
    rd_en = 1'b1; rd_row = 5'(row); rd_col = 6'(col);
    exp_q.push_back(e); name_q.push_back(n);
    tick();
    rd_en = 1'b0;
    chk({n, "_valid"}, int'(rd_valid), 1);
  endtask

  task automatic frame(input int p);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("plane", int'(plane), p);
    chk("on_time", int'(on_time), 32 << p);
  endtask

  task automatic wait_ready(input string n, input int exp);
    int k = 0;
    while (!wr_ready && k < 5000) begin
      tick();
      k++;
    end
    chk(n, k, exp);
  endtask

  // Monitor: every valid read pops the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got valid data %b expected no read", {dr, dg, db});
        end else begin
          string n;
          logic [5:0] e;
          n = name_q.pop_front();
          e = exp_q.pop_front();
          chk(n, int'({dr, dg, db}), int'(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; rd_en = 1'b0; frame_done = 1'b0; swap = 1'b0;
    wr_x = '0; wr_y = '0; wr_rgb = '0; rd_row = '0; rd_col = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(wr_ready), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_data", int'({dr, dg, db}), 0);
    chk("rst_plane", int'(plane), 0);
    chk("rst_on_time", int'(on_time), 32);
    chk("rst_pending", int'(swap_pending), 0);
    rst = 1'b0;
    wait_ready("init_clear_cycles", 2048);
    chk("idle_valid", int'(rd_valid), 0);
    rd(7, 9, 6'b000000, "r7c9_zero");
    wr(5, 3, '{4'hF, 4'h0, 4'hA});
    wr(5, 35, '{4'h1, 4'h8, 4'h0});
`ifdef DOUBLE_BUFFER_EN
    rd(3, 5, 6'b000000, "back_bank_hidden");
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk("swap_pending_set", int'(swap_pending), 1);
`else
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk("swap_ignored", int'(swap_pending), 0);
`endif
    frame(1);
    frame(2);
    frame(3);
`ifdef DOUBLE_BUFFER_EN
    chk("pending_before_wrap", int'(swap_pending), 1);
`endif
    frame(0);
`ifdef DOUBLE_BUFFER_EN
    chk("pending_after_wrap", int'(swap_pending), 0);
`endif
    rd(3, 5, 6'b110000, "p0_r3c5");
    rd_en = 1'b1; rd_row = 5'd3; rd_col = 6'd5; frame_done = 1'b1;
    exp_q.push_back(6'b110000); name_q.push_back("old_plane_on_frame_done");
    tick();
    rd_en = 1'b0; frame_done = 1'b0;
    chk("plane_after_coincident", int'(plane), 1);
    frame(2);
    frame(3);
    rd(3, 5, 6'b011001, "p3_r3c5");
    frame(0);
    wr_valid = 1'b1; wr_x = 6'd2; wr_y = 6'd2; wr_rgb = 12'hFFF;
    rd_en = 1'b1; rd_row = 5'd2; rd_col = 6'd2;
    exp_q.push_back(6'b000000); name_q.push_back("same_cycle_old");
    tick();
    wr_valid = 1'b0; rd_en = 1'b0;
`ifdef DOUBLE_BUFFER_EN
    rd(2, 2, 6'b000000, "next_cycle_back_hidden");
`else
    rd(2, 2, 6'b010101, "next_cycle_new");
`endif
    frame(1);
    frame(2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_ready_low", int'(wr_ready), 0);
    rd(3, 5, 6'b000000, "rd_during_clear");
    wait_ready("mid_clear_cycles", 2047);
    chk("plane_kept", int'(plane), 2);
    chk("on_time_kept", int'(on_time), 128);
    rd(3, 5, 6'b000000, "cleared_r3c5_p2");
    rd(7, 9, 6'b000000, "cleared_r7c9");
    rd(31, 63, 6'b000000, "cleared_r31c63");
    frame(3);
    rd(3, 5, 6'b000000, "cleared_r3c5_p3");
    rd(2, 2, 6'b000000, "cleared_r2c2");
    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
